// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register carrying {pc, data} through a 2-entry skid buffer.
// in_ready is a pure register; flush discards all entries and redirects the pc.
module pipe_stage_skid #(
  parameter int                PC_W   = 13,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Head entry (_p0) drives the outputs; skid entry (_p1) sits behind it.
  logic              vld_p0;
  logic [PC_W-1:0]   pc_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [DATA_W-1:0] data_p1;
  logic              in_ready_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              acc;
  logic              deq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [PC_W-1:0] pc_dec(input logic [PC_W-1:0] p);
    return p - PC_W'(1);
  endfunction

  assign acc = in_valid & in_ready_q;
  assign deq = vld_p0 & out_ready & ~stall;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      pc_p0       <= '1;
      data_p0     <= BUBBLE;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= '0;
    end else if (flush) begin
      // A mispredict is never held: flush beats stall and drops any transfer.
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      pc_p0       <= pc_dec(flush_pc);
      data_p0     <= BUBBLE;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= sat_inc(flush_cnt_q);
    end else if (!vld_p0) begin
      if (acc) begin
        vld_p0  <= 1'b1;
        pc_p0   <= in_pc;
        data_p0 <= in_data;
      end
    end else if (!vld_p1) begin
      if (acc && deq) begin
        pc_p0   <= in_pc;
        data_p0 <= in_data;
      end else if (acc) begin
        vld_p1     <= 1'b1;
        pc_p1      <= in_pc;
        data_p1    <= in_data;
        in_ready_q <= 1'b0;
      end else if (deq) begin
        vld_p0 <= 1'b0;
      end
    end else if (deq) begin
      pc_p0      <= pc_p1;
      data_p0    <= data_p1;
      vld_p1     <= 1'b0;
      in_ready_q <= 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = vld_p0;
  assign out_pc    = pc_p0;
  assign out_data  = vld_p0 ? data_p0 : BUBBLE;
  assign occupancy = {1'b0, vld_p0} + {1'b0, vld_p1};
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenario tasks plus a
// queue scoreboard that tracks every accepted payload until it is dequeued.
module tb_pipe_stage_skid;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_pc;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_pc;
  logic [31:0] out_data;
  logic        stall;
  logic        flush;
  logic [12:0] flush_pc;
  logic [1:0]  occupancy;
  logic [15:0] flush_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [12:0] s_out_pc;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_flush_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [12:0] pc;
    logic [31:0] data;
  } item_t;

  item_t       q[$];
  logic [12:0] last_pc = 13'h1FFF;

  always #5 CLK = ~CLK;

  pipe_stage_skid dut (
    .CLK(CLK), .NRST(NRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance sharing all inputs, used for saturation.
  pipe_stage_skid #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .NRST(NRST),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_data(s_out_data),
    .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .occupancy(s_occupancy), .flush_cnt(s_flush_cnt)
  );

  // Scoreboard: at each falling edge compare DUT state with the queue, then
  // apply the transfers the coming rising edge will perform.
  always @(negedge CLK) begin
    logic [12:0] exp_pc;
    logic [31:0] exp_data;
    exp_pc   = (q.size() != 0) ? q[0].pc : last_pc;
    exp_data = (q.size() != 0) ? q[0].data : 32'h0;
    checks++;
    if (occupancy !== 2'(q.size())) begin
      errors++; $display("FAIL sb_occupancy got %0d want %0d", occupancy, q.size());
    end
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++; $display("FAIL sb_out_valid got %b want %b", out_valid, q.size() != 0);
    end
    checks++;
    if (in_ready !== (q.size() < 2)) begin
      errors++; $display("FAIL sb_in_ready got %b want %b", in_ready, q.size() < 2);
    end
    checks++;
    if (out_pc !== exp_pc || out_data !== exp_data) begin
      errors++;
      $display("FAIL sb_head got pc=%h data=%h want pc=%h data=%h", out_pc, out_data, exp_pc, exp_data);
    end
    if (!NRST) begin
      q.delete();
      last_pc = 13'h1FFF;
    end else if (flush) begin
      q.delete();
      last_pc = flush_pc - 13'd1;
    end else begin
      if (out_valid && out_ready && !stall && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(item_t'{pc: in_pc, data: in_data});
      if (q.size() != 0) last_pc = q[0].pc;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = '0; in_data = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    idle_inputs();
    step(); step();
    NRST = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 13'h1FFF || out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out got v=%b pc=%h d=%h want 0/1fff/0", out_valid, out_pc, out_data);
    end
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++; $display("FAIL reset_ctrl got rdy=%b occ=%0d want 1/0", in_ready, occupancy);
    end
    checks++;
    if (flush_cnt !== 16'd0 || s_flush_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", flush_cnt, s_flush_cnt);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 13'(i); in_data = 32'hA0 + 32'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 13'(i) || out_data !== 32'hA0 + 32'(i) || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h d=%h occ=%0d want 1/%h/%h/1",
                 i, out_valid, out_pc, out_data, occupancy, 13'(i), 32'hA0 + 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 13'd2 || occupancy !== 2'd0) begin
      errors++; $display("FAIL stream_drain got v=%b pc=%h occ=%0d want 0/0002/0", out_valid, out_pc, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 13'h010; in_data = 32'hB0;
    step();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_one got occ=%0d rdy=%b want 1/1", occupancy, in_ready);
    end
    in_pc = 13'h011; in_data = 32'hB1;
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hB0) begin
      errors++; $display("FAIL b2b_full got occ=%0d rdy=%b d=%h want 2/0/b0", occupancy, in_ready, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 32'hB1 || out_pc !== 13'h011 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_deq1 got d=%h pc=%h occ=%0d rdy=%b want b1/0011/1/1", out_data, out_pc, occupancy, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL b2b_deq2 got v=%b occ=%0d want 0/0", out_valid, occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_pc = 13'h020; in_data = 32'hC0;
    step();
    in_pc = 13'h021; in_data = 32'hC1;
    step();
    in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (occupancy !== 2'd2 || out_data !== 32'hC0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d got occ=%0d d=%h rdy=%b want 2/c0/0", i, occupancy, out_data, in_ready);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (out_data !== 32'hC1 || occupancy !== 2'd1) begin
      errors++; $display("FAIL stall_release got d=%h occ=%0d want c1/1", out_data, occupancy);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_pc = 13'h030; in_data = 32'hD0;
    step();
    in_pc = 13'h031; in_data = 32'hD1;
    step();
    flush = 1'b1; stall = 1'b1; flush_pc = 13'h040;
    in_pc = 13'h032; in_data = 32'hD2;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 13'h03F || out_data !== 32'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full got v=%b pc=%h d=%h occ=%0d rdy=%b want 0/003f/0/0/1",
               out_valid, out_pc, out_data, occupancy, in_ready);
    end
    checks++;
    if (flush_cnt !== 16'd1) begin
      errors++; $display("FAIL flush_cnt1 got %0d want 1", flush_cnt);
    end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL flush_drop got v=%b occ=%0d want 0/0", out_valid, occupancy);
    end
    // One entry held, flush with a would-be accept and dequeue in the same cycle.
    in_valid = 1'b1; in_pc = 13'h050; in_data = 32'hE0;
    step();
    in_pc = 13'h051; in_data = 32'hE1; out_ready = 1'b1; flush = 1'b1; flush_pc = 13'h000;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 13'h1FFF || occupancy !== 2'd0 || flush_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_wrap got v=%b pc=%h occ=%0d cnt=%0d want 0/1fff/0/2", out_valid, out_pc, occupancy, flush_cnt);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    flush = 1'b1; flush_pc = 13'h100;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (flush_cnt !== 16'(3 + i) || s_flush_cnt !== 2'd3) begin
        errors++; $display("FAIL sat_%0d got %0d/%0d want %0d/3", i, flush_cnt, s_flush_cnt, 3 + i);
      end
    end
    flush = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_pc = 13'h060; in_data = 32'hF0;
    step();
    in_pc = 13'h061; in_data = 32'hF1;
    step();
    NRST = 1'b0; in_pc = 13'h062; in_data = 32'hF2; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 13'h1FFF || out_data !== 32'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got v=%b pc=%h d=%h occ=%0d rdy=%b want 0/1fff/0/0/1",
               out_valid, out_pc, out_data, occupancy, in_ready);
    end
    checks++;
    if (flush_cnt !== 16'd0 || s_flush_cnt !== 2'd0) begin
      errors++; $display("FAIL mid_reset_cnt got %0d/%0d want 0/0", flush_cnt, s_flush_cnt);
    end
    NRST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
  endtask

  initial begin
    NRST = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
